// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle RV32 control sequencer with memory stall timeout and retired-instruction count.
module cpu_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [9:0]  op_class,
    input  logic [2:0]  funct3,
    input  logic        take_branch,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        halt,
    output logic        fault,
    output logic [2:0]  state,
    output logic [31:0] instret
);
    localparam int CW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_fault;
    logic [31:0]   r_instret;
    logic [CW-1:0] r_stall;

    logic w_alu, w_lui, w_jal, w_jalr, w_br, w_ld, w_st, w_sys;
    logic w_illegal, w_stalled, w_timeout;

    assign w_alu  = op_class[0] | op_class[1] | op_class[5];
    assign w_br   = op_class[2];
    assign w_jalr = op_class[3];
    assign w_jal  = op_class[4];
    assign w_lui  = op_class[6];
    assign w_ld   = op_class[7];
    assign w_st   = op_class[8];
    assign w_sys  = op_class[9];

    assign w_illegal = !$onehot(op_class)
                     || (w_ld && (funct3 == 3'd3 || funct3 >= 3'd6))
                     || (w_st && funct3 > 3'd2);

    // Timeout fires on the edge that would complete the MEM_TIMEOUT-th consecutive stalled cycle.
    assign w_stalled = mem_req && !mem_ready;
    assign w_timeout = (MEM_TIMEOUT != 0) && w_stalled
                     && ({1'b0, r_stall} + (CW+1)'(1) == (CW+1)'(MEM_TIMEOUT));

    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_we    = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = 2'b00;
        pc_we    = 1'b0;
        pc_sel   = 2'b00;
        case (r_state)
            S_FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ready;
            end
            S_EXEC: begin
                rf_we  = w_alu | w_lui | w_jal | w_jalr;
                pc_we  = w_alu | w_lui | w_jal | w_jalr | w_br;
                wb_sel = w_lui ? 2'b11 : (w_jal | w_jalr) ? 2'b10 : 2'b00;
                pc_sel = w_jal ? 2'b10 : w_jalr ? 2'b11 : (w_br && take_branch) ? 2'b01 : 2'b00;
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = w_st;
                pc_we    = w_st && mem_ready;
            end
            S_WB: begin
                rf_we  = 1'b1;
                wb_sel = 2'b01;
                pc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    assign halt    = (r_state == S_HALT);
    assign fault   = r_fault;
    assign state   = r_state;
    assign instret = r_instret;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_FETCH;
            r_fault   <= 1'b0;
            r_instret <= '0;
            r_stall   <= '0;
        end else begin
            r_instret <= r_instret + {31'd0, pc_we};
            r_stall   <= w_stalled ? r_stall + CW'(1) : '0;
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) r_state <= S_DECODE;
                    else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (w_illegal) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end else r_state <= w_sys ? S_HALT : S_EXEC;
                end
                S_EXEC: r_state <= (w_ld || w_st) ? S_MEM : S_FETCH;
                S_MEM: begin
                    if (mem_ready) r_state <= w_st ? S_FETCH : S_WB;
                    else if (w_timeout) begin
                        r_state <= S_HALT;
                        r_fault <= 1'b1;
                    end
                end
                S_WB:   r_state <= S_FETCH;
                S_HALT: ;
                default: begin
                    r_state <= S_HALT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed bench for cpu_ctrl_fsm with hand-computed state and strobe vectors.
module tb_cpu_ctrl_fsm;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [9:0]  op_class = 10'h001;
    logic [2:0]  funct3 = 3'd0;
    logic        take_branch = 1'b0;
    logic        mem_ready = 1'b1;
    logic        mem_req, mem_we, addr_sel, ir_we, rf_we, pc_we, halt, fault;
    logic [1:0]  wb_sel, pc_sel;
    logic [2:0]  state;
    logic [31:0] instret;
    logic [10:0] strb;
    int tests = 0;
    int failed = 0;

    // strb = {mem_req, mem_we, addr_sel, ir_we, rf_we, wb_sel, pc_we, pc_sel, halt}
    localparam logic [10:0] FR  = 11'b1001_0_00_0_00_0;
    localparam logic [10:0] FS  = 11'b1000_0_00_0_00_0;
    localparam logic [10:0] NO  = 11'b0000_0_00_0_00_0;
    localparam logic [10:0] ALU = 11'b0000_1_00_1_00_0;
    localparam logic [10:0] ML  = 11'b1010_0_00_0_00_0;
    localparam logic [10:0] WBS = 11'b0000_1_01_1_00_0;
    localparam logic [10:0] MS  = 11'b1110_0_00_1_00_0;
    localparam logic [10:0] MSS = 11'b1110_0_00_0_00_0;
    localparam logic [10:0] BT  = 11'b0000_0_00_1_01_0;
    localparam logic [10:0] BN  = 11'b0000_0_00_1_00_0;
    localparam logic [10:0] HL  = 11'b0000_0_00_0_00_1;
    localparam logic [10:0] JL  = 11'b0000_1_10_1_10_0;
    localparam logic [10:0] JR  = 11'b0000_1_10_1_11_0;
    localparam logic [10:0] LU  = 11'b0000_1_11_1_00_0;

    assign strb = {mem_req, mem_we, addr_sel, ir_we, rf_we, wb_sel, pc_we, pc_sel, halt};

    always #5 clk = ~clk;

    cpu_ctrl_fsm #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .resetn(resetn), .op_class(op_class), .funct3(funct3),
        .take_branch(take_branch), .mem_ready(mem_ready), .mem_req(mem_req),
        .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we), .rf_we(rf_we),
        .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .halt(halt),
        .fault(fault), .state(state), .instret(instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [2:0] s, input logic [10:0] e);
        #1;
        chk({tag, ".state"}, {29'd0, state}, {29'd0, s});
        chk({tag, ".strb"}, {21'd0, strb}, {21'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic rst(input logic mr);
        resetn = 1'b0;
        mem_ready = mr;
        #1;
        chk("rst.state", {29'd0, state}, 32'd0);
        chk("rst.fault", {31'd0, fault}, 32'd0);
        chk("rst.instret", instret, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic fde(input string tag, input logic [10:0] e_exec);
        step({tag, ".f"}, 3'd0, FR);
        step({tag, ".d"}, 3'd1, NO);
        step({tag, ".e"}, 3'd2, e_exec);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst0.state", {29'd0, state}, 32'd0);
        chk("rst0.fault", {31'd0, fault}, 32'd0);
        chk("rst0.instret", instret, 32'd0);
        resetn = 1'b1;
        fde("addi", ALU);
        chk("addi.instret", instret, 32'd1);
        op_class = 10'h080; funct3 = 3'd2;
        fde("lw", NO);
        mem_ready = 1'b0;
        repeat (3) step("lw.mstall", 3'd3, ML);
        mem_ready = 1'b1;
        step("lw.mready", 3'd3, ML);
        step("lw.wb", 3'd4, WBS);
        chk("lw.instret", instret, 32'd2);
        op_class = 10'h100;
        fde("sw", NO);
        step("sw.m", 3'd3, MS);
        chk("sw.instret", instret, 32'd3);
        op_class = 10'h004; funct3 = 3'd0; take_branch = 1'b1;
        fde("beq_t", BT);
        take_branch = 1'b0;
        fde("beq_n", BN);
        chk("beq.instret", instret, 32'd5);
        op_class = 10'h010; fde("jal", JL);
        op_class = 10'h008; fde("jalr", JR);
        op_class = 10'h040; fde("lui", LU);
        op_class = 10'h020; fde("auipc", ALU);
        chk("jmp.instret", instret, 32'd9);
        op_class = 10'h100; funct3 = 3'd2;
        fde("sw2", NO);
        mem_ready = 1'b0;
        step("sw2.mstall", 3'd3, MSS);
        resetn = 1'b0;
        #1;
        chk("midmem.state", {29'd0, state}, 32'd0);
        chk("midmem.instret", instret, 32'd0);
        chk("midmem.fault", {31'd0, fault}, 32'd0);
        resetn = 1'b1;
        step("rel", 3'd0, FS);
        step("rel.clk1", 3'd0, FS);
        mem_ready = 1'b1; op_class = 10'h003;
        step("bad.f", 3'd0, FR);
        step("bad.d", 3'd1, NO);
        step("bad.h", 3'd5, HL);
        chk("bad.fault", {31'd0, fault}, 32'd1);
        mem_ready = 1'b0; op_class = 10'h001;
        step("bad.h2", 3'd5, HL);
        chk("bad.instret", instret, 32'd0);
        rst(1'b1);
        op_class = 10'h200;
        step("sys.f", 3'd0, FR);
        step("sys.d", 3'd1, NO);
        step("sys.h", 3'd5, HL);
        chk("sys.fault", {31'd0, fault}, 32'd0);
        rst(1'b1);
        op_class = 10'h080; funct3 = 3'd6;
        step("ldbad.f", 3'd0, FR);
        step("ldbad.d", 3'd1, NO);
        step("ldbad.h", 3'd5, HL);
        chk("ldbad.fault", {31'd0, fault}, 32'd1);
        rst(1'b1);
        op_class = 10'h100; funct3 = 3'd3;
        step("stbad.f", 3'd0, FR);
        step("stbad.d", 3'd1, NO);
        step("stbad.h", 3'd5, HL);
        chk("stbad.fault", {31'd0, fault}, 32'd1);
        op_class = 10'h001; funct3 = 3'd0;
        rst(1'b0);
        repeat (4) step("to.f", 3'd0, FS);
        step("to.h", 3'd5, HL);
        chk("to.fault", {31'd0, fault}, 32'd1);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
